wb_stage: RTL and testbench

MEM/WB pipeline register plus writeback logic for the five-stage MIPS32 core; it is the write-side initiator for grf. It latches the MEM-stage result, performs load byte/halfword extraction and extension, and selects the writeback source. It drives grf's regwrite/write_reg/write_data/pc_new. It also exports the same value as a forwarding source and keeps a retired-instruction counter.

---
 rtl/wb_stage_pkg.sv | 21 ++
 rtl/wb_stage_if.sv | 31 +++
 rtl/wb_stage_load_ext.sv | 40 ++++
 rtl/wb_stage.sv | 100 ++++++++++
 tb/tb_wb_stage.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_pkg.sv
// Shared codes for the MEM/WB stage: writeback-source select, load types, reset PC.
package wb_stage_pkg;

  localparam logic [31:0] WB_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    WBSEL_ALU = 2'd0,
    WBSEL_MEM = 2'd1,
    WBSEL_PC8 = 2'd2,
    WBSEL_RSV = 2'd3
  } wbsel_e;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LBU = 3'd2,
    LD_LH  = 3'd3,
    LD_LHU = 3'd4
  } ldtype_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB bus and the grf write / forwarding / retire-count outputs of the WB stage.
interface wb_stage_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  m_valid;
  logic [31:0]           m_pc;
  logic [REG_ADDR_W-1:0] m_rd;
  logic                  m_regwrite;
  logic [1:0]            m_wbsel;
  logic [2:0]            m_ldtype;
  logic [DATA_W-1:0]     m_alu_result;
  logic [DATA_W-1:0]     m_mem_rdata;

  logic                  regwrite;
  logic [REG_ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0]     write_data;
  logic [31:0]           pc_new;
  logic                  fwd_valid;
  logic [31:0]           instret;

  modport master (
    output m_valid, m_pc, m_rd, m_regwrite, m_wbsel, m_ldtype, m_alu_result, m_mem_rdata,
    input  regwrite, write_reg, write_data, pc_new, fwd_valid, instret
  );

  modport slave (
    input  m_valid, m_pc, m_rd, m_regwrite, m_wbsel, m_ldtype, m_alu_result, m_mem_rdata,
    output regwrite, write_reg, write_data, pc_new, fwd_valid, instret
  );
endinterface

// File: rtl/wb_stage_load_ext.sv
// Combinational load extraction: picks the addressed byte/halfword and sign/zero-extends it.
module load_ext
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_off,
  input  logic [2:0]        i_ldtype,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    unique case (i_off)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    // Halfword ignores off[0]; a misaligned lh returns the enclosing aligned half.
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_data = i_word;
    case (i_ldtype)
      LD_LB:   o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      LD_LBU:  o_data = {{(DATA_W-8){1'b0}}, w_byte};
      LD_LH:   o_data = {{(DATA_W-16){w_half[15]}}, w_half};
      LD_LHU:  o_data = {{(DATA_W-16){1'b0}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, writeback-source mux, grf write port and retire counter.
// Optional WB_TRACE_EN: simulation-only trace print of every committed register write.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter logic [31:0] RESET_PC   = WB_RESET_PC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       flush,
  wb_stage_if.slave  bus
);

  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_regwrite;
  wbsel_e                r_wbsel;
  ldtype_e               r_ldtype;
  logic [DATA_W-1:0]     r_alu;
  logic [DATA_W-1:0]     r_rdata;
  logic [31:0]           r_pc;
  logic [31:0]           r_instret;

  logic                  w_regwrite;
  logic [DATA_W-1:0]     w_ld_data;
  logic [DATA_W-1:0]     w_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_wbsel    <= WBSEL_ALU;
      r_ldtype   <= LD_LW;
      r_alu      <= '0;
      r_rdata    <= '0;
      r_pc       <= RESET_PC;
    end else if (flush) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_pc       <= RESET_PC;
    end else if (!stall) begin
      r_valid    <= bus.m_valid;
      r_rd       <= bus.m_rd;
      r_regwrite <= bus.m_regwrite;
      r_wbsel    <= wbsel_e'(bus.m_wbsel);
      r_ldtype   <= ldtype_e'(bus.m_ldtype);
      r_alu      <= bus.m_alu_result;
      r_rdata    <= bus.m_mem_rdata;
      r_pc       <= bus.m_pc;
    end
  end

  // Counted as the instruction is accepted into WB, so instret includes the one now writing back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instret <= '0;
    end else if (!flush && !stall && bus.m_valid) begin
      r_instret <= r_instret + 32'd1;
    end
  end

  load_ext #(
    .DATA_W (DATA_W)
  ) u_load_ext (
    .i_word   (r_rdata),
    .i_off    (r_alu[1:0]),
    .i_ldtype (r_ldtype),
    .o_data   (w_ld_data)
  );

  always_comb begin
    w_regwrite = r_valid & r_regwrite & (r_rd != '0);
    w_wdata    = r_alu;
    case (r_wbsel)
      WBSEL_MEM: w_wdata = w_ld_data;
      WBSEL_PC8: w_wdata = DATA_W'(r_pc + 32'd8);
      default:   w_wdata = r_alu;
    endcase
  end

  assign bus.regwrite   = w_regwrite;
  assign bus.write_reg  = w_regwrite ? r_rd : '0;
  assign bus.write_data = w_wdata;
  assign bus.pc_new     = r_pc;
  assign bus.fwd_valid  = w_regwrite;
  assign bus.instret    = r_instret;

`ifdef WB_TRACE_EN
  always @(posedge clk) begin
    if (!reset && w_regwrite) begin
      $display("@%h: $%d <= %h", r_pc, r_rd, w_wdata);
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed scoreboard bench for wb_stage: loads, jal, $0 writes, stall/flush priority, reset, instret wrap.
module tb_wb_stage;

  logic clk;
  logic rst;
  logic stall;
  logic flush;

  wb_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  wb_stage #(
    .DATA_W     (32),
    .REG_ADDR_W (5),
    .RESET_PC   (32'h0000_3000)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        fv;
    logic [31:0] ins;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // reference state of the WB slot
  logic        mv, mrw;
  logic [4:0]  mrd;
  logic [1:0]  mwbsel;
  logic [2:0]  mld;
  logic [31:0] malu, mrdata, mpc, minst;

  function automatic logic [31:0] ld_model(input logic [2:0] t, input logic [31:0] w, input logic [1:0] off);
    logic [31:0] sb8, sh16;
    sb8  = w >> (8 * int'(off));
    sh16 = w >> (16 * int'(off[1]));
    case (t)
      3'd1:    return 32'($signed(sb8[7:0]));
      3'd2:    return sb8 & 32'h0000_00FF;
      3'd3:    return 32'($signed(sh16[15:0]));
      3'd4:    return sh16 & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  function automatic exp_t exp_now();
    exp_t e;
    e.rw  = mv && mrw && (mrd != 5'd0);
    e.wr  = e.rw ? mrd : 5'd0;
    e.wd  = (mwbsel == 2'd1) ? ld_model(mld, mrdata, malu[1:0]) :
            (mwbsel == 2'd2) ? mpc + 32'd8 : malu;
    e.pc  = mpc;
    e.fv  = e.rw;
    e.ins = minst;
    return e;
  endfunction

  task automatic model_reset();
    mv = 0; mrw = 0; mrd = 0; mwbsel = 0; mld = 0; malu = 0; mrdata = 0;
    mpc = 32'h0000_3000; minst = 0;
  endtask

  task automatic model_step();
    if (!flush && !stall && bus.m_valid) minst = minst + 32'd1;
    if (flush) begin
      mv = 0; mrw = 0; mpc = 32'h0000_3000;
    end else if (!stall) begin
      mv = bus.m_valid; mrw = bus.m_regwrite; mrd = bus.m_rd; mwbsel = bus.m_wbsel;
      mld = bus.m_ldtype; malu = bus.m_alu_result; mrdata = bus.m_mem_rdata; mpc = bus.m_pc;
    end
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag, input exp_t e);
    cmp({tag, ".regwrite"},   32'(bus.regwrite),  32'(e.rw));
    cmp({tag, ".write_reg"},  32'(bus.write_reg), 32'(e.wr));
    cmp({tag, ".write_data"}, bus.write_data,     e.wd);
    cmp({tag, ".pc_new"},     bus.pc_new,         e.pc);
    cmp({tag, ".fwd_valid"},  32'(bus.fwd_valid), 32'(e.fv));
    cmp({tag, ".instret"},    bus.instret,        e.ins);
  endtask

  task automatic drv(input logic v, input logic [31:0] pc, input logic [4:0] rd, input logic rw,
                     input logic [1:0] wbsel, input logic [2:0] ld, input logic [31:0] alu,
                     input logic [31:0] rdata);
    bus.m_valid = v; bus.m_pc = pc; bus.m_rd = rd; bus.m_regwrite = rw;
    bus.m_wbsel = wbsel; bus.m_ldtype = ld; bus.m_alu_result = alu; bus.m_mem_rdata = rdata;
  endtask

  // push expectation, clock once, pop and check against the DUT
  task automatic apply(input string tag);
    exp_t e;
    model_step();
    sb.push_back(exp_now());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compare(tag, e);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drv(0, 32'h0, 5'd0, 0, 2'd0, 3'd0, 32'h0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare("reset", exp_now());
    rst = 1'b0;

    drv(1, 32'h3004, 5'd8, 1, 2'd0, 3'd0, 32'h1234_5678, 32'h0);
    apply("alu");
    cmp("alu_const_data", bus.write_data, 32'h1234_5678);
    cmp("alu_const_instret", bus.instret, 32'd1);

    drv(1, 32'h3008, 5'd9, 1, 2'd1, 3'd1, 32'h0000_1001, 32'h8899_AABB);
    apply("lb_off1");
    cmp("lb_const", bus.write_data, 32'hFFFF_FFAA);
    drv(1, 32'h300C, 5'd10, 1, 2'd1, 3'd2, 32'h0000_1003, 32'h8899_AABB);
    apply("lbu_off3");
    cmp("lbu_const", bus.write_data, 32'h0000_0088);
    drv(1, 32'h3010, 5'd11, 1, 2'd1, 3'd3, 32'h0000_1002, 32'h8899_AABB);
    apply("lh_off2");
    cmp("lh_const", bus.write_data, 32'hFFFF_8899);
    drv(1, 32'h3014, 5'd12, 1, 2'd1, 3'd4, 32'h0000_1000, 32'h8899_AABB);
    apply("lhu_off0");
    cmp("lhu_const", bus.write_data, 32'h0000_AABB);
    drv(1, 32'h3018, 5'd13, 1, 2'd1, 3'd0, 32'h0000_1001, 32'h8899_AABB);
    apply("lw_misaligned");
    drv(1, 32'h301C, 5'd14, 1, 2'd1, 3'd3, 32'h0000_1003, 32'h7F00_1234);
    apply("lh_off3");
    drv(1, 32'h3020, 5'd15, 1, 2'd1, 3'd7, 32'h0000_1002, 32'hCAFE_BABE);
    apply("ld_reserved");

    drv(1, 32'h3010, 5'd31, 1, 2'd2, 3'd0, 32'h0000_0000, 32'h0);
    apply("jal");
    cmp("jal_const", bus.write_data, 32'h0000_3018);
    drv(1, 32'hFFFF_FFFC, 5'd31, 1, 2'd2, 3'd0, 32'h0000_0000, 32'h0);
    apply("pc8_wrap");
    drv(1, 32'h3024, 5'd3, 1, 2'd3, 3'd0, 32'h5555_AAAA, 32'h0);
    apply("wbsel_rsv");

    drv(1, 32'h3028, 5'd0, 1, 2'd0, 3'd0, 32'h0BAD_0BAD, 32'h0);
    apply("rd0_write");
    drv(1, 32'h302C, 5'd7, 0, 2'd0, 3'd0, 32'h0000_0077, 32'h0);
    apply("no_regwrite");
    drv(0, 32'h3030, 5'd7, 1, 2'd0, 3'd0, 32'h0000_0078, 32'h0);
    apply("bubble_in");

    drv(1, 32'h3034, 5'd5, 1, 2'd0, 3'd0, 32'hCAFE_0001, 32'h0);
    apply("pre_stall");
    stall = 1'b1;
    drv(1, 32'h4000, 5'd6, 1, 2'd0, 3'd0, 32'hDEAD_BEEF, 32'h0);
    apply("stall1");
    apply("stall2");
    apply("stall3");
    flush = 1'b1;
    apply("flush_stall");
    flush = 1'b0; stall = 1'b0;
    apply("post_flush");

    // asynchronous reset in the middle of a stall
    stall = 1'b1;
    drv(1, 32'h5000, 5'd4, 1, 2'd0, 3'd0, 32'h0000_4444, 32'h0);
    apply("stall_before_rst");
    #3 rst = 1'b1;
    #1;
    model_reset();
    compare("async_rst", exp_now());
    #2 rst = 1'b0;
    stall = 1'b0;
    apply("after_rst");

    // instret wrap: preload the counter while stalled, then retire one
    stall = 1'b1;
    apply("wrap_hold");
    force dut.r_instret = 32'hFFFF_FFFF;
    #1 release dut.r_instret;
    minst = 32'hFFFF_FFFF;
    #1;
    cmp("wrap_pre", bus.instret, minst);
    stall = 1'b0;
    drv(1, 32'h6000, 5'd2, 1, 2'd0, 3'd0, 32'h0000_0002, 32'h0);
    apply("wrap");
    cmp("wrap_const", bus.instret, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
